// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter_if
// Brief    : Requester/master-side signal bundle of the SPI bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_bus_arbiter_if #(
    parameter int DataWidth    = 8,
    parameter int GuardWidth   = 8,
    parameter int TimeoutWidth = 16
);
    logic [1:0]              Req_i;
    logic [1:0]              Grant_o;
    logic [1:0]              Write_i;
    logic [1:0]              ReadNext_i;
    logic [DataWidth-1:0]    Data0_i;
    logic [DataWidth-1:0]    Data1_i;
    logic [1:0]              CPOL_i;
    logic [1:0]              CPHA_i;
    logic [1:0]              LSBFE_i;
    logic                    SPI_Write_o;
    logic                    SPI_ReadNext_o;
    logic [DataWidth-1:0]    SPI_Data_o;
    logic                    SPI_CPOL_o;
    logic                    SPI_CPHA_o;
    logic                    SPI_LSBFE_o;
    logic                    SPI_Transmission_i;
    logic                    SPI_FIFOEmpty_i;
    logic [GuardWidth-1:0]   GuardPreset_i;
    logic [TimeoutWidth-1:0] TimeoutPreset_i;
    logic                    Timeout_o;

    modport slave (
        input  Req_i, Write_i, ReadNext_i, Data0_i, Data1_i,
        input  CPOL_i, CPHA_i, LSBFE_i,
        input  SPI_Transmission_i, SPI_FIFOEmpty_i,
        input  GuardPreset_i, TimeoutPreset_i,
        output Grant_o, SPI_Write_o, SPI_ReadNext_o, SPI_Data_o,
        output SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o, Timeout_o
    );

    modport master (
        output Req_i, Write_i, ReadNext_i, Data0_i, Data1_i,
        output CPOL_i, CPHA_i, LSBFE_i,
        output SPI_Transmission_i, SPI_FIFOEmpty_i,
        output GuardPreset_i, TimeoutPreset_i,
        input  Grant_o, SPI_Write_o, SPI_ReadNext_o, SPI_Data_o,
        input  SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o, Timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Brief    : Round-robin sharing of one SPI master between two requesters,
//            with idle-gated release, guard gap and hold-time watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
    parameter int DataWidth    = 8,
    parameter int GuardWidth   = 8,
    parameter int TimeoutWidth = 16
) (
    input  wire logic         Clk_i,
    input  wire logic         Reset_i,
    spi_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_GUARD  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_lg;
    logic [1:0]              r_grant;
    logic                    r_cpol;
    logic                    r_cpha;
    logic                    r_lsbfe;
    logic                    r_timeout;
    logic [GuardWidth-1:0]   r_guard;
    logic [TimeoutWidth-1:0] r_wdog;

    logic                    w_granted;
    logic                    w_idx;
    logic                    w_release;
    logic                    w_wdog_fire;
    logic [TimeoutWidth-1:0] w_wdog_limit;

    always_comb begin
        w_granted    = (r_state == S_GRANT0) || (r_state == S_GRANT1);
        w_idx        = (r_state == S_GRANT1);
        w_wdog_limit = bus.TimeoutPreset_i - TimeoutWidth'(1);
        w_wdog_fire  = (bus.TimeoutPreset_i != '0) && (r_wdog >= w_wdog_limit);
        // Release waits for the master to drain, not just for Req to drop.
        w_release    = !bus.Req_i[w_idx] && !bus.SPI_Transmission_i
                       && bus.SPI_FIFOEmpty_i;
    end

    always_comb begin
        bus.SPI_Write_o    = 1'b0;
        bus.SPI_ReadNext_o = 1'b0;
        bus.SPI_Data_o     = '0;
        if (w_granted) begin
            bus.SPI_Write_o    = bus.Write_i[w_idx];
            bus.SPI_ReadNext_o = bus.ReadNext_i[w_idx];
            bus.SPI_Data_o     = w_idx ? bus.Data1_i : bus.Data0_i;
        end
    end

    assign bus.Grant_o     = r_grant;
    assign bus.SPI_CPOL_o  = r_cpol;
    assign bus.SPI_CPHA_o  = r_cpha;
    assign bus.SPI_LSBFE_o = r_lsbfe;
    assign bus.Timeout_o   = r_timeout;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            r_state   <= S_IDLE;
            r_lg      <= 1'b1;
            r_grant   <= 2'b00;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsbfe   <= 1'b0;
            r_timeout <= 1'b0;
            r_guard   <= '0;
            r_wdog    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // With both requesting, the one not granted last wins.
                    if (bus.Req_i[0] && (!bus.Req_i[1] || r_lg)) begin
                        r_state <= S_GRANT0;
                        r_grant <= 2'b01;
                        r_lg    <= 1'b0;
                        r_cpol  <= bus.CPOL_i[0];
                        r_cpha  <= bus.CPHA_i[0];
                        r_lsbfe <= bus.LSBFE_i[0];
                        r_wdog  <= '0;
                    end else if (bus.Req_i[1]) begin
                        r_state <= S_GRANT1;
                        r_grant <= 2'b10;
                        r_lg    <= 1'b1;
                        r_cpol  <= bus.CPOL_i[1];
                        r_cpha  <= bus.CPHA_i[1];
                        r_lsbfe <= bus.LSBFE_i[1];
                        r_wdog  <= '0;
                    end
                end
                S_GRANT0, S_GRANT1: begin
                    if (w_wdog_fire || w_release) begin
                        r_state   <= S_GUARD;
                        r_grant   <= 2'b00;
                        r_guard   <= bus.GuardPreset_i;
                        r_timeout <= w_wdog_fire;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + TimeoutWidth'(1);
                    end
                end
                S_GUARD: begin
                    if (r_guard == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_guard <= r_guard - GuardWidth'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Brief    : Scoreboard bench for spi_bus_arbiter against an ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_bus_arbiter_if bus ();
    spi_bus_arbiter dut (.Clk_i(clk), .Reset_i(rst), .bus(bus));

    typedef struct {
        logic [1:0] grant;
        logic       cpol, cpha, lsbfe, tmo, wr, rn;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int tmo_seen = 0;

    logic [1:0]  n_req = 0, n_wr = 0, n_rn = 0, n_cpol = 0, n_cpha = 0, n_lsbfe = 0;
    logic [7:0]  n_d0 = 0, n_d1 = 0, n_gpre = 0;
    logic [15:0] n_tpre = 0;
    logic        n_trans = 0, n_fempty = 1;

    // Reference model: who owns the bus, guard cycles left, granted cycles.
    int   m_owner, m_guard_left, m_held;
    bit   m_lg;
    logic m_cpol, m_cpha, m_lsbfe, m_to;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void apply();
        bus.Req_i = n_req; bus.Write_i = n_wr; bus.ReadNext_i = n_rn;
        bus.Data0_i = n_d0; bus.Data1_i = n_d1;
        bus.CPOL_i = n_cpol; bus.CPHA_i = n_cpha; bus.LSBFE_i = n_lsbfe;
        bus.SPI_Transmission_i = n_trans; bus.SPI_FIFOEmpty_i = n_fempty;
        bus.GuardPreset_i = n_gpre; bus.TimeoutPreset_i = n_tpre;
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_guard_left = 0; m_held = 0; m_lg = 1'b1;
        m_cpol = 0; m_cpha = 0; m_lsbfe = 0; m_to = 0;
    endfunction

    function automatic void model_edge();
        bit fire, rel;
        int n;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            fire = (bus.TimeoutPreset_i != 0) && (m_held >= int'(bus.TimeoutPreset_i));
            rel  = !bus.Req_i[m_owner] && !bus.SPI_Transmission_i && bus.SPI_FIFOEmpty_i;
            if (fire || rel) begin
                m_owner = -1;
                m_guard_left = int'(bus.GuardPreset_i) + 1;
                m_to = fire;
            end
        end else if (m_guard_left > 0) begin
            m_guard_left--;
        end else begin
            if (bus.Req_i == 2'b11) n = m_lg ? 0 : 1;
            else if (bus.Req_i[0]) n = 0;
            else if (bus.Req_i[1]) n = 1;
            else n = -1;
            if (n >= 0) begin
                m_owner = n; m_lg = (n == 1); m_held = 0;
                m_cpol = bus.CPOL_i[n]; m_cpha = bus.CPHA_i[n]; m_lsbfe = bus.LSBFE_i[n];
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e.cpol = m_cpol; e.cpha = m_cpha; e.lsbfe = m_lsbfe; e.tmo = m_to;
        e.wr   = (m_owner >= 0) ? bus.Write_i[m_owner] : 1'b0;
        e.rn   = (m_owner >= 0) ? bus.ReadNext_i[m_owner] : 1'b0;
        e.data = (m_owner == 0) ? bus.Data0_i : (m_owner == 1) ? bus.Data1_i : 8'h00;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_grant", bus.Grant_o, e.grant);
            check("sb_cpol", bus.SPI_CPOL_o, e.cpol);
            check("sb_cpha", bus.SPI_CPHA_o, e.cpha);
            check("sb_lsbfe", bus.SPI_LSBFE_o, e.lsbfe);
            check("sb_timeout", bus.Timeout_o, e.tmo);
            check("sb_write", bus.SPI_Write_o, e.wr);
            check("sb_readnext", bus.SPI_ReadNext_o, e.rn);
            check("sb_data", bus.SPI_Data_o, e.data);
        end
        if (bus.Timeout_o === 1'b1) tmo_seen++;
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        apply();
        push_exp();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero();
        check("rst_grant", bus.Grant_o, 2'b00);
        check("rst_write", bus.SPI_Write_o, 1'b0);
        check("rst_readnext", bus.SPI_ReadNext_o, 1'b0);
        check("rst_data", bus.SPI_Data_o, 8'h00);
        check("rst_mode", {bus.SPI_CPOL_o, bus.SPI_CPHA_o, bus.SPI_LSBFE_o}, 3'b000);
        check("rst_timeout", bus.Timeout_o, 1'b0);
    endtask

    // Asserted between clock edges so the outputs must clear asynchronously.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_zero();
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply();
        push_exp();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        bit reached;
        rst = 1'b1;
        apply();
        #4;
        check_zero();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply();
        push_exp();

        // Requester 0 alone; mode bits and same-cycle datapath
        n_cpol = 2'b01; n_cpha = 2'b11; n_lsbfe = 2'b10;
        n_req = 2'b01;
        step();
        step();
        #1;
        check("t1_grant", bus.Grant_o, 2'b01);
        check("t1_mode", {bus.SPI_CPOL_o, bus.SPI_CPHA_o, bus.SPI_LSBFE_o}, 3'b110);
        n_wr = 2'b01; n_d0 = 8'h3C;
        step();
        #1;
        check("t1_write", bus.SPI_Write_o, 1'b1);
        check("t1_data", bus.SPI_Data_o, 8'h3C);
        n_wr = 2'b10; n_d1 = 8'hA5; n_d0 = 8'h5A;
        step();
        #1;
        check("t4_other_write", bus.SPI_Write_o, 1'b0);
        check("t4_data", bus.SPI_Data_o, 8'h5A);
        n_wr = 2'b00; n_req = 2'b00;
        run(4);

        // Simultaneous requests, guard gap of 4, then requester 1
        do_reset();
        n_req = 2'b11; n_gpre = 8'd3;
        run(2);
        #1;
        check("t2_first", bus.Grant_o, 2'b01);
        run(2);
        n_req = 2'b10;
        step();
        step();
        #1;
        check("t2_release", bus.Grant_o, 2'b00);
        run(4);
        #1;
        check("t2_gap", bus.Grant_o, 2'b00);
        step();
        #1;
        check("t2_second", bus.Grant_o, 2'b10);
        check("t2_mode", {bus.SPI_CPOL_o, bus.SPI_CPHA_o, bus.SPI_LSBFE_o}, 3'b011);
        n_req = 2'b00;
        run(8);

        // Release held off while the master is still shifting
        n_req = 2'b01;
        run(2);
        n_req = 2'b00; n_trans = 1'b1;
        run(5);
        #1;
        check("t3_hold", bus.Grant_o, 2'b01);
        n_trans = 1'b0;
        step();
        #1;
        check("t3_hold_last", bus.Grant_o, 2'b01);
        step();
        #1;
        check("t3_release", bus.Grant_o, 2'b00);
        run(6);

        // Watchdog at 10 granted cycles
        n_tpre = 16'd10; t0 = tmo_seen;
        n_req = 2'b01;
        run(11);
        #1;
        check("t5_before", bus.Grant_o, 2'b01);
        step();
        #1;
        check("t5_forced", bus.Grant_o, 2'b00);
        check("t5_pulse", bus.Timeout_o, 1'b1);
        run(2);
        check("t5_once", tmo_seen - t0, 1);
        n_req = 2'b00; n_tpre = 16'd0;
        run(8);

        // Watchdog disabled
        n_req = 2'b01;
        run(1000);
        #1;
        check("t5_disabled", bus.Grant_o, 2'b01);
        n_req = 2'b00;
        run(3);

        // Reset mid-grant, then mid-guard
        n_req = 2'b11;
        run(3);
        do_reset();
        step();
        #1;
        check("t6_after_reset", bus.Grant_o, 2'b01);
        n_req = 2'b00; n_gpre = 8'd5;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step();
            reached = (m_guard_left > 0);
        end
        check("t6_guard_reached", reached, 1'b1);
        run(1);
        do_reset();

        // Randomized traffic
        for (int p = 0; p < 5; p++) begin
            n_gpre = 8'($urandom_range(0, 4));
            case ($urandom_range(0, 2))
                0: n_tpre = 16'd0;
                1: n_tpre = 16'd6;
                default: n_tpre = 16'd25;
            endcase
            n_cpol = 2'($urandom); n_cpha = 2'($urandom); n_lsbfe = 2'($urandom);
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 9) == 0) n_req[0] = ~n_req[0];
                if ($urandom_range(0, 9) == 0) n_req[1] = ~n_req[1];
                n_wr = 2'($urandom); n_rn = 2'($urandom);
                n_d0 = 8'($urandom); n_d1 = 8'($urandom);
                n_trans  = ($urandom_range(0, 3) == 0);
                n_fempty = ($urandom_range(0, 3) != 0);
                step();
                if ($urandom_range(0, 199) == 0) do_reset();
            end
        end
        n_req = 2'b00;
        run(2);
        #10;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI master (write/read-next FIFO interface plus CPOL/CPHA/LSBFE mode bits) between two SPI sequencing FSMs, e.g. two sensor-measurement FSMs on one SPI bus.
- Grants the bus round-robin and routes the granted requester's control and data onto the master.
- Releases the bus only after the master is idle, then inserts a programmable guard gap.
- A watchdog force-releases a requester that holds the bus too long.
- Each requester drives its own chip select; this block does not touch chip selects.

Parameters:
- DataWidth, 8, width of the SPI data byte path.
- GuardWidth, 8, width of the guard-gap counter and of GuardPreset_i.
- TimeoutWidth, 16, width of the watchdog counter and of TimeoutPreset_i.

Ports:
- Clk_i  in  1  clock, rising edge.
- Reset_i  in  1  asynchronous reset, active-high.
- Req_i  in  2  bus request, bit n = requester n; held high for the whole access.
- Grant_o  out  2  one-hot grant, or 0 when no requester holds the bus; registered.
- Write_i  in  2  per-requester SPI write strobe.
- ReadNext_i  in  2  per-requester SPI read-next strobe.
- Data0_i  in  DataWidth  requester 0 write data.
- Data1_i  in  DataWidth  requester 1 write data.
- CPOL_i, CPHA_i, LSBFE_i  in  2 each  per-requester SPI mode bits; stable while Req_i is high.
- SPI_Write_o  out  1  write strobe to the master.
- SPI_ReadNext_o  out  1  read-next strobe to the master.
- SPI_Data_o  out  DataWidth  write data to the master.
- SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o  out  1 each  mode bits to the master; registered.
- SPI_Transmission_i  in  1  master shifting.
- SPI_FIFOEmpty_i  in  1  master TX FIFO empty.
- GuardPreset_i  in  GuardWidth  guard gap length.
- TimeoutPreset_i  in  TimeoutWidth  maximum granted cycles; 0 disables the watchdog.
- Timeout_o  out  1  one-cycle pulse when the watchdog force-releases.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: Grant_o=00, SPI_Write_o=0, SPI_ReadNext_o=0, SPI_Data_o=0, CPOL/CPHA/LSBFE=0, Timeout_o=0.
  - State=IDLE; last-grant pointer LG=1, so requester 0 wins first.
  - Reset mid-transfer drops the grant at once; no guard gap follows.
- States: IDLE, GRANT0, GRANT1, GUARD.
- IDLE:
  - One request: grant it.
  - Both requesting: grant the requester not equal to LG.
  - Grant_o rises on the clock edge after Req_i is sampled high (latency 1).
  - On entry to GRANTn: latch requester n's CPOL/CPHA/LSBFE into the mode registers, set LG=n, clear the watchdog counter.
- GRANTn, datapath:
  - SPI_Write_o = Write_i[n]; SPI_ReadNext_o = ReadNext_i[n]; SPI_Data_o = Data{n}_i. All combinational.
  - Strobes from the non-granted requester are ignored.
  - Outside GRANTx both strobes are forced 0 and SPI_Data_o=0.
- GRANTn, release:
  - Condition: Req_i[n]=0 AND SPI_Transmission_i=0 AND SPI_FIFOEmpty_i=1 in the same cycle.
  - On release: go to GUARD, Grant_o=00, guard counter loaded with GuardPreset_i.
  - While the master is busy, the grant holds even if Req_i[n] has dropped.
- Watchdog:
  - In GRANTx the counter increments each cycle and saturates.
  - When TimeoutPreset_i≠0 and count reaches TimeoutPreset_i-1, the next edge forces GUARD regardless of Req/transmission state, with Timeout_o=1 for that one cycle.
  - TimeoutPreset_i=1 therefore forces release after one granted cycle.
- GUARD:
  - Counter decrements each cycle; when it is 0, go to IDLE on the next edge.
  - GuardPreset_i=0 gives one GUARD cycle; preset G gives G+1 cycles.
  - Requests seen during GUARD are not granted before IDLE.
- Mode bits hold the last latched values outside GRANTx and never change mid-grant, so there is no SCK polarity glitch.
- Fairness: a requester still holding Req_i high after its own release is granted again only if the other requester is not requesting in IDLE.
- Grant_o is never 11.

Test Plan:
- After reset, Req_i=01 → Grant_o=01 one cycle later; CPOL/CPHA/LSBFE take requester 0 values (1,1,0); Write_i[0] pulses reach SPI_Write_o in the same cycle.
- Req_i=11 simultaneously after reset → requester 0 granted. After it releases and GuardPreset_i=3: GUARD lasts 4 cycles, then requester 1 is granted with its own mode bits.
- Requester 0 drops Req while SPI_Transmission_i=1 for 5 cycles → Grant_o stays 01 until transmission=0 and FIFOEmpty=1, then 00.
- While requester 0 is granted, Write_i[1] and Data1_i=0xA5 → SPI_Write_o=0; SPI_Data_o follows Data0_i.
- TimeoutPreset_i=10, requester holds Req → Grant_o drops after 10 granted cycles; Timeout_o pulses exactly once. TimeoutPreset_i=0 → no release for 1000 cycles.
- Reset_i asserted mid-grant and mid-guard → all outputs 0 without a clock edge. After deassert with Req_i=11 → requester 0 granted first.
